// File: rtl/spi_arb_pkg.sv
// Shared types and default sizing for the SPI bus arbiter.
// Combinational/compile-time only: no latency, no backpressure.
package spi_arb_pkg;

    localparam int NUM_REQ_DEF    = 4;
    localparam int DATA_W_DEF     = 8;
    localparam int GAP_CYCLES_DEF = 2;

    localparam int CNT_W = $clog2(DATA_W_DEF);
    localparam int IDX_W = $clog2(NUM_REQ_DEF);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        DONE  = 3'd3,
        GAP   = 3'd4
    } state_t;

endpackage

// File: rtl/spi_arb_pick.sv
// Winner select from pending requests; round-robin from ptr_i when SPI_ARB_RR_EN, else lowest index.
// Purely combinational (zero latency); requesters that lose simply keep req high.
module spi_arb_pick
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int IW      = IDX_W
) (
    input  logic [NUM_REQ-1:0] req_i,
`ifdef SPI_ARB_RR_EN
    input  logic [IW-1:0]      ptr_i,
`endif
    output logic               vld_o,
    output logic [IW-1:0]      idx_o
);

    always_comb begin
        vld_o = 1'b0;
        idx_o = '0;
`ifdef SPI_ARB_RR_EN
        // Walk offsets high to low so the smallest offset from the pointer wins.
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            if (req_i[(int'(ptr_i) + off) % NUM_REQ]) begin
                vld_o = 1'b1;
                idx_o = IW'((int'(ptr_i) + off) % NUM_REQ);
            end
        end
`else
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                vld_o = 1'b1;
                idx_o = IW'(i);
            end
        end
`endif
    end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI bus between NUM_REQ requesters; one LSB-first DATA_W-bit frame per grant.
// done pulses DATA_W+2 cycles after CS_n falls; frame period DATA_W+3+GAP_CYCLES.
// Losers wait with req held; SPI_ARB_RR_EN selects round-robin instead of fixed priority.
module spi_bus_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic                      SCLK,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] tx_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rx_data,
    output logic [NUM_REQ-1:0]        CS_n,
    output logic                      MOSI,
    input  logic                      MISO,
    output logic                      busy
);

    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [NUM_REQ-1:0]  cs_n_q, cs_n_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                pick_vld;
    logic [IW-1:0]       pick_idx;
    logic [NUM_REQ-1:0]  pick_oh;
`ifdef SPI_ARB_RR_EN
    logic [IW-1:0]       ptr_q, ptr_d;
`endif

    spi_arb_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req_i (req),
`ifdef SPI_ARB_RR_EN
        .ptr_i (ptr_q),
`endif
        .vld_o (pick_vld),
        .idx_o (pick_idx)
    );

    always_comb begin
        pick_oh           = '0;
        pick_oh[pick_idx] = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        grant_d   = grant_q;
        done_d    = '0;
        cs_n_d    = cs_n_q;
        idx_d     = idx_q;
`ifdef SPI_ARB_RR_EN
        ptr_d     = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    tx_sh_d = tx_data[int'(pick_idx)*DATA_W +: DATA_W];
                    grant_d = pick_oh;
                    cs_n_d  = ~pick_oh;
                    idx_d   = pick_idx;
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: state_d = SHIFT;
            SHIFT: begin
                rx_sh_d[cnt_q] = MISO;
                if (cnt_q == CW'(DATA_W - 1)) begin
                    // Deselect on the last bit so the slave sees CS_n high through DONE.
                    cs_n_d  = '1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                rx_data_d = rx_sh_q;
                done_d    = grant_q;
                grant_d   = '0;
                gap_d     = '0;
                state_d   = GAP;
`ifdef SPI_ARB_RR_EN
                ptr_d     = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
`endif
            end
            GAP: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) state_d = IDLE;
                else                              gap_d   = gap_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge SCLK) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            gap_q     <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            cs_n_q    <= '1;
            idx_q     <= '0;
`ifdef SPI_ARB_RR_EN
            ptr_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            cs_n_q    <= cs_n_d;
            idx_q     <= idx_d;
`ifdef SPI_ARB_RR_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    always_comb begin
        MOSI = 1'b0;
        if (state_q == SETUP)      MOSI = tx_sh_q[0];
        else if (state_q == SHIFT) MOSI = tx_sh_q[cnt_q];
    end

    assign grant   = grant_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign CS_n    = cs_n_q;
    assign busy    = (state_q != IDLE);

endmodule
